tap_prescaler: RTL

//  Free-running prescaler that feeds the taps[] bus of the stepped counters. Exposes NTAPS evenly spaced bits
//  of a WIDTH-bit counter as levels, plus one-cycle rising-edge strobes per tap. Adds run/stop/single-burst

---
 rtl/tap_prescaler_pkg.sv | 17 +
 rtl/tap_prescaler_sync2.sv | 32 +++
 rtl/tap_prescaler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tap_prescaler_pkg.sv
// Shared definitions for the tap prescaler: FSM state encodings and the
// tap-bit placement function (also used by stepped_counter so both sides
// of the taps bus agree on spacing).
package tap_prescaler_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_SINGLE  = 2'd2
    } state_e;

    // Counter bit exposed as tap i: evenly spaced from bit 0 to bit width-1.
    function automatic int tapbit(input int i, input int width, input int ntaps);
        return (i * (width - 1)) / (ntaps - 1);
    endfunction

endpackage

// File: rtl/tap_prescaler_sync2.sv
// Two-flop control synchroniser with async active-low reset (reset value 0).
// BYPASS=1 passes the input straight through for builds without
// synchronisation.
module tap_prescaler_sync2 #(
    parameter bit BYPASS = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    generate
        if (BYPASS) begin : g_bypass
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign q_o      = d_i;
        end else begin : g_sync
            logic [1:0] ff_q;
            // Shift the asynchronous level through two flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ff_q <= 2'b00;
                end else begin
                    ff_q <= {ff_q[0], d_i};
                end
            end
            assign q_o = ff_q[1];
        end
    endgenerate

endmodule

// File: rtl/tap_prescaler.sv
// Free-running prescaler feeding the taps[] bus. Exposes NTAPS evenly spaced
// counter bits as levels plus one-cycle rising-edge strobes, with run /
// single-burst / clear control.
// Build option: define TAP_PRESCALER_SYNC_EN to pass run, single and clear
// through 2-flop synchronisers (single is then edge-detected).
module tap_prescaler
    import tap_prescaler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NTAPS = 6,
    parameter int SELW  = $clog2(NTAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             single,
    input  logic [SELW-1:0]  single_sel,
    input  logic             clear,
    output logic [NTAPS-1:0] taps,
    output logic [NTAPS-1:0] tap_stb,
    output logic [WIDTH-1:0] cnt,
    output logic             running
);

`ifdef TAP_PRESCALER_SYNC_EN
    localparam bit SyncBypass = 1'b0;
`else
    localparam bit SyncBypass = 1'b1;
`endif

    logic             run_s;
    logic             single_lvl_s;
    logic             single_s;
    logic             clear_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic [NTAPS-1:0] rise_s;
    logic [SELW-1:0]  sel_eff_s;
    logic [SELW:0]    sel_ext_s;
    logic             sel_rise_s;
    logic             active_s;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [NTAPS-1:0] stb_q, stb_d;
    logic             running_q;

    tap_prescaler_sync2 #(.BYPASS(SyncBypass)) u_sync_run (
        .clk(clk), .rst_n(rst_n), .d_i(run), .q_o(run_s)
    );
    tap_prescaler_sync2 #(.BYPASS(SyncBypass)) u_sync_single (
        .clk(clk), .rst_n(rst_n), .d_i(single), .q_o(single_lvl_s)
    );
    tap_prescaler_sync2 #(.BYPASS(SyncBypass)) u_sync_clear (
        .clk(clk), .rst_n(rst_n), .d_i(clear), .q_o(clear_s)
    );

`ifdef TAP_PRESCALER_SYNC_EN
    logic single_prev_q;
    // Remember the previous synchronised single level so a held button fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_prev_q <= 1'b0;
        end else begin
            single_prev_q <= single_lvl_s;
        end
    end
    assign single_s = single_lvl_s & ~single_prev_q;
`else
    assign single_s = single_lvl_s;
`endif

    assign cnt_inc_s = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        for (genvar g = 0; g < NTAPS; g++) begin : g_tap
            localparam int B = tapbit(g, WIDTH, NTAPS);
            assign taps[g]   = cnt_q[B];
            assign rise_s[g] = ~cnt_q[B] & cnt_inc_s[B];
        end
    endgenerate

    // Clamp out-of-range burst selectors to the highest tap and pick its rising edge.
    always_comb begin
        sel_ext_s = {1'b0, single_sel};
        if (sel_ext_s >= (SELW+1)'(NTAPS)) begin
            sel_eff_s = SELW'(NTAPS - 1);
        end else begin
            sel_eff_s = single_sel;
        end
        sel_rise_s = rise_s[sel_eff_s];
    end

    // Next-state logic: FSM transitions, counter update and strobe generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stb_d    = '0;
        active_s = (state_q != ST_STOPPED);
        case (state_q)
            ST_STOPPED: begin
                if (run_s) begin
                    state_d = ST_RUNNING;
                end else if (single_s) begin
                    state_d = ST_SINGLE;
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (!run_s) begin
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_SINGLE: begin
                if (run_s) begin
                    state_d = ST_RUNNING;
                end else if (!clear_s && sel_rise_s) begin
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ST_SINGLE;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
        if (clear_s) begin
            cnt_d = '0;
            stb_d = '0;
        end else if (active_s) begin
            cnt_d = cnt_inc_s;
            stb_d = rise_s;
        end else begin
            cnt_d = cnt_q;
            stb_d = '0;
        end
    end

    // State, counter, strobe and running-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            stb_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            running_q <= (state_d != ST_STOPPED);
        end
    end

    assign cnt     = cnt_q;
    assign tap_stb = stb_q;
    assign running = running_q;

endmodule
